uart_rx: RTL and testbench
==========================

# uart_rx

Oversampling UART receiver. It recovers frames from the serial line `RX_IN`, checks start, parity and stop bits, and presents each good byte as a single-cycle `Data_valid` pulse on `P_DATA`. It is the receive-side counterpart of the UART TX path and uses the same frame format: 1 start bit (0), DATA_WIDTH data bits sent LSB first, an optional parity bit, and 1 stop bit (1). It runs in the RX clock domain, which is Prescale times the baud rate.

## Interface
- `DATA_WIDTH`, default 8: number of data bits per frame.
- `PRESCALE_WIDTH`, default 6: width of the `Prescale` input.
- `CLK` input, 1 bit: RX oversampling clock. Single clock domain.
- `RST` input, 1 bit: asynchronous, active-low reset.
- `RX_IN` input, 1 bit: serial line, idles high. Already synchronized upstream.
- `Prescale` input, PRESCALE_WIDTH bits: oversampling ratio. Legal values are 8, 16 and 32; any other value gives undefined behaviour.
- `PAR_EN` input, 1 bit: parity bit present in the frame.
- `PAR_TYP` input, 1 bit: 0 selects even parity, 1 selects odd parity.
- `P_DATA` output, DATA_WIDTH bits: last good byte. Holds its value between frames.
- `Data_valid` output, 1 bit: one-cycle pulse when `P_DATA` is updated.
- `Parity_Error` output, 1 bit: one-cycle pulse when the received parity bit does not match.
- `Stop_Error` output, 1 bit: one-cycle pulse when the stop bit samples as 0 (framing error).

## Operation
- States: IDLE, START, DATA, PARITY, STOP. All are registered; next-state logic is combinational.
- Counters:
  - `edge_cnt` counts 0..Prescale-1 within each bit and wraps to 0.
  - `bit_cnt` counts data bits 0..DATA_WIDTH-1.
- Sampling: take `RX_IN` at `edge_cnt` = P/2-1, P/2 and P/2+1, where P = Prescale. The bit value is the 2-of-3 majority. It is registered and stable from `edge_cnt` = P/2+2.
- Bit decisions are made at `edge_cnt` = P-1 (the end of the bit), called EOB below.
- Transitions:
  - IDLE: when `RX_IN`=0, go to START and latch `Prescale`, `PAR_EN` and `PAR_TYP` for this frame. Input changes mid-frame are ignored.
  - START: at EOB, go to DATA if the sampled bit is 0. If it is 1, treat it as a glitch and go back to IDLE with no error flag.
  - DATA: at each EOB, shift the sampled bit into the deserializer at the MSB and shift right, so the byte ends up LSB-first. At EOB with `bit_cnt`=DATA_WIDTH-1, go to PARITY if parity is enabled, otherwise to STOP.
  - PARITY: at EOB, compare the sampled bit with the expected parity. Even parity expects the XOR of the data bits; odd parity expects its inverse. On mismatch, pulse `Parity_Error` and mark the frame bad. Then go to STOP.
  - STOP: at EOB, if the sampled bit is 0, pulse `Stop_Error`. If it is 1 and the frame is not marked bad, load `P_DATA` and pulse `Data_valid`. Next state is START if `RX_IN`=0 on that cycle, otherwise IDLE.
- A bad frame never updates `P_DATA` and never asserts `Data_valid`.
- A parity error and a stop error in the same frame pulse both flags, each in its own bit period's EOB+1 cycle.
- Reset values: state IDLE, counters 0, deserializer 0, `P_DATA`=0, `Data_valid`=0, `Parity_Error`=0, `Stop_Error`=0.
- Reset mid-frame aborts immediately with no output pulse. After reset release, the receiver waits for a fresh falling edge while in IDLE.

## Timing
- Let t be the first cycle IDLE sees `RX_IN`=0. START occupies cycles t+1 .. t+P, with `edge_cnt`=0 at t+1.
- Frame length is N = 10 bit periods without parity and 11 with parity (for DATA_WIDTH=8).
- `Data_valid`, `Stop_Error` and `P_DATA` change are registered and appear in cycle t+N·P+1. They are high for exactly one cycle.
- `Parity_Error` appears in cycle t+(N-1)·P+1.
- Back-to-back frames with no idle gap:
  - The next start bit is detected in the STOP EOB cycle.
  - The following frame's START begins the next cycle. No frame is lost.
- Earliest glitch rejection is cycle t+P; IDLE is re-entered in cycle t+P+1.

## Structure
- Shared package `uart_rx_pkg` holds:
  - the state encoding enum (3 bits),
  - the legal prescale constants (8, 16, 32),
  - the majority-vote function.
- The TX controller already defines a frame-state enum. Both the TX and RX enums live in the shared UART package.
- Sub-module `uart_rx_sampler` contains `edge_cnt`, the three-tap capture and the majority vote. It outputs `sampled_bit` and `eob`, and has an enable input driven by the FSM (low in IDLE).
- The top level holds the FSM, `bit_cnt`, the deserializer and the parity/stop checkers.

## Test plan
- 0xA5, Prescale 8, PAR_EN=0 → `Data_valid` in cycle t+81, `P_DATA`=0xA5, no error flags.
- 0x3C, Prescale 16, even parity, parity bit 0 → `Data_valid` in cycle t+177, `P_DATA`=0x3C.
- 0x3C, Prescale 16, odd parity, parity bit 0 → `Parity_Error` in cycle t+161, no `Data_valid`, `P_DATA` unchanged.
- 0x55, Prescale 32, stop bit 0 → `Stop_Error` in cycle t+321, no `Data_valid`.
- `RX_IN` low for 3 cycles at Prescale 16 → return to IDLE in cycle t+17, all outputs 0.
- Further required scenarios:
  - Two back-to-back frames, 0x01 then 0xFE, at Prescale 8 → two `Data_valid` pulses exactly 80 cycles apart.
  - `RST` asserted mid-DATA → all outputs 0 immediately. The next clean frame is received correctly.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: frame-state encodings for both directions,
// the legal oversampling ratios and the 2-of-3 majority vote.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_e;

    localparam int unsigned PRESCALE_8  = 8;
    localparam int unsigned PRESCALE_16 = 16;
    localparam int unsigned PRESCALE_32 = 32;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit edge counter with three-tap capture around mid-bit; produces the
// majority-voted bit value and an end-of-bit strobe.
module uart_rx_sampler
    import uart_rx_pkg::*;
#(
    parameter int unsigned PRESCALE_WIDTH = 6
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      en,
    input  logic                      RX_IN,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    output logic                      sampled_bit,
    output logic                      eob
);

    logic [PRESCALE_WIDTH-1:0] edge_cnt;
    logic [PRESCALE_WIDTH-1:0] half;
    logic                      tap0;
    logic                      tap1;

    assign half = prescale >> 1;
    assign eob  = en && (edge_cnt == prescale - PRESCALE_WIDTH'(1));

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            edge_cnt    <= '0;
            tap0        <= 1'b0;
            tap1        <= 1'b0;
            sampled_bit <= 1'b0;
        end else if (!en) begin
            edge_cnt <= '0;
        end else begin
            edge_cnt <= eob ? '0 : edge_cnt + PRESCALE_WIDTH'(1);
            if (edge_cnt == half - PRESCALE_WIDTH'(1))
                tap0 <= RX_IN;
            if (edge_cnt == half)
                tap1 <= RX_IN;
            // third tap is taken live, so the vote is registered on the P/2+1 edge
            if (edge_cnt == half + PRESCALE_WIDTH'(1))
                sampled_bit <= majority3(tap0, tap1, RX_IN);
        end
    end

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: frame FSM, deserializer and parity/stop
// checking on top of the mid-bit sampler.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned PRESCALE_WIDTH = 6
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      RX_IN,
    input  logic [PRESCALE_WIDTH-1:0] Prescale,
    input  logic                      PAR_EN,
    input  logic                      PAR_TYP,
    output logic [DATA_WIDTH-1:0]     P_DATA,
    output logic                      Data_valid,
    output logic                      Parity_Error,
    output logic                      Stop_Error
);

    localparam int unsigned BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    rx_state_e                 state;
    logic [BCW-1:0]            bit_cnt;
    logic [DATA_WIDTH-1:0]     shreg;
    logic                      frame_bad;
    logic [PRESCALE_WIDTH-1:0] prescale_q;
    logic                      par_en_q;
    logic                      par_typ_q;
    logic                      sampled_bit;
    logic                      eob;

    uart_rx_sampler #(
        .PRESCALE_WIDTH(PRESCALE_WIDTH)
    ) u_sampler (
        .CLK        (CLK),
        .RST        (RST),
        .en         (state != RX_IDLE),
        .RX_IN      (RX_IN),
        .prescale   (prescale_q),
        .sampled_bit(sampled_bit),
        .eob        (eob)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state        <= RX_IDLE;
            bit_cnt      <= '0;
            shreg        <= '0;
            frame_bad    <= 1'b0;
            prescale_q   <= PRESCALE_WIDTH'(PRESCALE_8);
            par_en_q     <= 1'b0;
            par_typ_q    <= 1'b0;
            P_DATA       <= '0;
            Data_valid   <= 1'b0;
            Parity_Error <= 1'b0;
            Stop_Error   <= 1'b0;
        end else begin
            Data_valid   <= 1'b0;
            Parity_Error <= 1'b0;
            Stop_Error   <= 1'b0;
            case (state)
                RX_IDLE: begin
                    if (!RX_IN) begin
                        state      <= RX_START;
                        prescale_q <= Prescale;
                        par_en_q   <= PAR_EN;
                        par_typ_q  <= PAR_TYP;
                        frame_bad  <= 1'b0;
                        bit_cnt    <= '0;
                    end
                end
                RX_START: begin
                    if (eob)
                        state <= sampled_bit ? RX_IDLE : RX_DATA;
                end
                RX_DATA: begin
                    if (eob) begin
                        shreg <= DATA_WIDTH'({sampled_bit, shreg} >> 1);
                        if (bit_cnt == BCW'(DATA_WIDTH - 1)) begin
                            bit_cnt <= '0;
                            state   <= par_en_q ? RX_PARITY : RX_STOP;
                        end else begin
                            bit_cnt <= bit_cnt + BCW'(1);
                        end
                    end
                end
                RX_PARITY: begin
                    if (eob) begin
                        if (sampled_bit != (par_typ_q ^ (^shreg))) begin
                            Parity_Error <= 1'b1;
                            frame_bad    <= 1'b1;
                        end
                        state <= RX_STOP;
                    end
                end
                RX_STOP: begin
                    if (eob) begin
                        if (!sampled_bit) begin
                            Stop_Error <= 1'b1;
                        end else if (!frame_bad) begin
                            P_DATA     <= shreg;
                            Data_valid <= 1'b1;
                        end
                        // a start bit already on the line begins the next frame with no idle gap
                        if (!RX_IN) begin
                            state      <= RX_START;
                            prescale_q <= Prescale;
                            par_en_q   <= PAR_EN;
                            par_typ_q  <= PAR_TYP;
                            frame_bad  <= 1'b0;
                        end else begin
                            state <= RX_IDLE;
                        end
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames are serialized from a byte-level model,
// expected pulses are queued at issue time and matched by an output monitor.
module tb_uart_rx;
    import uart_rx_pkg::*;

    localparam int DW = 8;
    localparam int PW = 6;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          RX_IN = 1'b1;
    logic [PW-1:0] Prescale = 6'd8;
    logic          PAR_EN = 1'b0;
    logic          PAR_TYP = 1'b0;
    logic [DW-1:0] P_DATA;
    logic          Data_valid;
    logic          Parity_Error;
    logic          Stop_Error;

    uart_rx #(
        .DATA_WIDTH    (DW),
        .PRESCALE_WIDTH(PW)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .RX_IN       (RX_IN),
        .Prescale    (Prescale),
        .PAR_EN      (PAR_EN),
        .PAR_TYP     (PAR_TYP),
        .P_DATA      (P_DATA),
        .Data_valid  (Data_valid),
        .Parity_Error(Parity_Error),
        .Stop_Error  (Stop_Error)
    );

    always #5 CLK = ~CLK;

    int unsigned cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int          kind;   // 0 data valid, 1 parity error, 2 stop error
        logic [7:0]  data;
        int unsigned at;
    } ev_t;

    ev_t         exp_q[$];
    int unsigned dv_times[$];
    int          checks = 0;
    int          errors = 0;
    logic [7:0]  last_good = 8'h00;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic consume(input int kind);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pulse kind=%0d at cycle %0d, nothing expected", kind, cyc);
        end else begin
            e = exp_q.pop_front();
            check("pulse_kind", kind, e.kind);
            check("pulse_cycle", cyc, e.at);
            check("p_data", P_DATA, e.data);
        end
    endtask

    always @(negedge CLK) begin
        if (Data_valid) begin
            dv_times.push_back(cyc);
            consume(0);
        end
        if (Parity_Error) consume(1);
        if (Stop_Error)   consume(2);
    end

    // Called at posedge+1; leaves at posedge+1 after the stop bit (plus idle if not back-to-back)
    task automatic send_frame(input logic [7:0] data, input int p, input bit pe, input bit pt,
                              input bit bad_par, input bit stop_val, input bit b2b);
        int unsigned t;
        int          ones;
        int          n;
        bit          par_bit;
        bit          bits[$];
        Prescale = PW'(p);
        PAR_EN   = pe;
        PAR_TYP  = pt;
        t = cyc;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(data[i]);
        par_bit = pt ? ((ones % 2) == 0) : ((ones % 2) == 1);
        if (bad_par) par_bit = !par_bit;
        n = pe ? 11 : 10;
        if (pe && bad_par)
            exp_q.push_back('{kind: 1, data: last_good, at: t + 10 * p + 1});
        if (!stop_val) begin
            exp_q.push_back('{kind: 2, data: last_good, at: t + n * p + 1});
        end else if (!(pe && bad_par)) begin
            last_good = data;
            exp_q.push_back('{kind: 0, data: data, at: t + n * p + 1});
        end
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(data[i]);
        if (pe) bits.push_back(par_bit);
        bits.push_back(stop_val);
        foreach (bits[i]) begin
            RX_IN = bits[i];
            repeat (p) @(posedge CLK);
            #1;
        end
        if (!b2b) begin
            RX_IN = 1'b1;
            repeat ($urandom_range(20, 3)) @(posedge CLK);
            #1;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 3000 && exp_q.size() != 0; i++) @(posedge CLK);
        #1;
        check("queue_drained", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        #20000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int unsigned t;
        int          p;
        bit          pe, pt, b2b_prev;

        // reset state
        #2 RST = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_p_data", P_DATA, 0);
        check("rst_data_valid", Data_valid, 0);
        check("rst_parity_error", Parity_Error, 0);
        check("rst_stop_error", Stop_Error, 0);
        RST = 1'b1;
        repeat (4) @(posedge CLK);
        #1;

        send_frame(8'hA5, 8, 0, 0, 0, 1, 0);
        send_frame(8'h3C, 16, 1, 0, 0, 1, 0);
        send_frame(8'h3C, 16, 1, 1, 1, 1, 0);
        send_frame(8'h55, 32, 0, 0, 0, 0, 0);
        send_frame(8'hC3, 16, 1, 0, 1, 0, 0);
        drain();

        // short glitch at Prescale 16
        Prescale = PW'(16);
        PAR_EN   = 1'b0;
        RX_IN    = 1'b0;
        t = cyc;
        repeat (3) @(posedge CLK);
        #1;
        RX_IN = 1'b1;
        repeat (13) @(posedge CLK);
        #1;
        check("glitch_cycle_base", cyc, t + 16);
        check("glitch_still_start", int'(dut.state), int'(RX_START));
        @(posedge CLK);
        #1;
        check("glitch_back_idle", int'(dut.state), int'(RX_IDLE));
        check("glitch_dv", Data_valid, 0);
        check("glitch_perr", Parity_Error, 0);
        check("glitch_serr", Stop_Error, 0);
        check("glitch_p_data", P_DATA, last_good);
        repeat (5) @(posedge CLK);
        #1;

        // back-to-back frames
        dv_times.delete();
        send_frame(8'h01, 8, 0, 0, 0, 1, 1);
        send_frame(8'hFE, 8, 0, 0, 0, 1, 0);
        drain();
        check("b2b_pulse_count", dv_times.size(), 2);
        if (dv_times.size() == 2)
            check("b2b_spacing", dv_times[1] - dv_times[0], 80);

        // reset in the middle of the data bits
        Prescale = PW'(16);
        PAR_EN   = 1'b0;
        RX_IN    = 1'b0;
        repeat (16) @(posedge CLK);
        #1;
        RX_IN = 1'b1;
        repeat (16) @(posedge CLK);
        #1;
        RX_IN = 1'b0;
        repeat (20) @(posedge CLK);
        #3;
        RST = 1'b0;
        #1;
        check("midrst_p_data", P_DATA, 0);
        check("midrst_dv", Data_valid, 0);
        check("midrst_perr", Parity_Error, 0);
        check("midrst_serr", Stop_Error, 0);
        last_good = 8'h00;
        RX_IN = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b1;
        repeat (4) @(posedge CLK);
        #1;
        check("post_rst_idle", int'(dut.state), int'(RX_IDLE));
        send_frame(8'h96, 16, 1, 0, 0, 1, 0);
        drain();

        // randomized frames; back-to-back runs keep one configuration
        b2b_prev = 1'b0;
        p = 8; pe = 0; pt = 0;
        for (int k = 0; k < 40; k++) begin
            bit b2b;
            bit bad_par;
            bit stop_val;
            if (!b2b_prev) begin
                case ($urandom_range(2, 0))
                    0:       p = 8;
                    1:       p = 16;
                    default: p = 32;
                endcase
                pe = 1'($urandom_range(1, 0));
                pt = 1'($urandom_range(1, 0));
            end
            bad_par  = pe && ($urandom_range(7, 0) == 0);
            stop_val = ($urandom_range(7, 0) != 0);
            b2b      = (k != 39) && ($urandom_range(3, 0) == 0);
            send_frame(8'($urandom), p, pe, pt, bad_par, stop_val, b2b);
            b2b_prev = b2b;
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
